// File: rtl/tri_matmul_if.sv
// Operand/result bundle for the lower-triangular matrix multiplier.
// The master drives start and the operands; the slave returns status and the product.
interface tri_matmul_if #(
  parameter int N = 3,
  parameter int W = 8
);
  logic             start;
  logic [W*N*N-1:0] A_in;
  logic [W*N*N-1:0] B_in;
  logic             busy;
  logic             done;
  logic [W*N*N-1:0] C_out;

  modport master (
    output start, A_in, B_in,
    input  busy, done, C_out
  );

  modport slave (
    input  start, A_in, B_in,
    output busy, done, C_out
  );
endinterface

// File: rtl/tri_matmul.sv
// Sequential lower-triangular matrix product C = A*B, one MAC per cycle.
// Define TRI_MATMUL_SAT_EN to saturate results to W bits instead of wrapping.
module tri_matmul #(
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  tri_matmul_if.slave  mm
);
  localparam int MW = W*N*N;
  localparam int AW = 2*W + $clog2(N) + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N-1);
`ifdef TRI_MATMUL_SAT_EN
  localparam logic signed [AW-1:0] SMAX =
    {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN =
    {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WRITE
  } state_e;

  state_e                st_q;
  logic [IW-1:0]         i_q, j_q, k_q;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [MW-1:0]         a_q, b_q, c_q, c_d, cout_q;
  logic                  busy_q, done_q;
  logic signed [W-1:0]   a_el, b_el, red_d;
  logic signed [2*W-1:0] prod;

  // k only walks j..i, so upper-triangle operand bits are never read
  always_comb begin
    a_el  = a_q[W*(N*int'(i_q) + int'(k_q)) +: W];
    b_el  = b_q[W*(N*int'(k_q) + int'(j_q)) +: W];
    prod  = a_el * b_el;
    acc_d = acc_q + {{(AW-2*W){prod[2*W-1]}}, prod};
`ifdef TRI_MATMUL_SAT_EN
    if (acc_q > SMAX)
      red_d = SMAX[W-1:0];
    else if (acc_q < SMIN)
      red_d = SMIN[W-1:0];
    else
      red_d = acc_q[W-1:0];
`else
    red_d = acc_q[W-1:0];
`endif
    c_d = c_q;
    c_d[W*(N*int'(i_q) + int'(j_q)) +: W] = red_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      cout_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (st_q)
        IDLE: begin
          if (mm.start) begin
            a_q    <= mm.A_in;
            b_q    <= mm.B_in;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            acc_q  <= '0;
            busy_q <= 1'b1;
            st_q   <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (k_q == i_q)
            st_q <= WRITE;
          else
            k_q <= k_q + 1'b1;
        end
        WRITE: begin
          c_q   <= c_d;
          acc_q <= '0;
          st_q  <= MAC;
          if (j_q == i_q) begin
            if (i_q == LAST) begin
              cout_q <= c_d;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              st_q   <= IDLE;
            end else begin
              i_q <= i_q + 1'b1;
              j_q <= '0;
              k_q <= '0;
            end
          end else begin
            j_q <= j_q + 1'b1;
            k_q <= j_q + 1'b1;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign mm.busy  = busy_q;
  assign mm.done  = done_q;
  assign mm.C_out = cout_q;
endmodule

// File: tb/tb_tri_matmul.sv
// Scoreboard bench for tri_matmul at N=3, W=8.
// Expected products come from a behavioural model queued at launch.
module tb_tri_matmul;
  localparam int N = 3;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   dn_cnt = 0;
  logic [71:0] sb[$];

  tri_matmul_if #(.N(N), .W(W)) mif ();

  tri_matmul #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .mm  (mif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got,
                     input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] mk(input int m[9]);
    logic [71:0] r;
    r = '0;
    for (int x = 0; x < 9; x++) r[8*x +: 8] = m[x][7:0];
    return r;
  endfunction

  function automatic logic [71:0] model(input logic [71:0] a,
                                        input logic [71:0] b);
    logic [71:0]       r;
    logic signed [7:0] x, y;
    longint            acc;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j <= i; j++) begin
        acc = 0;
        for (int k = j; k <= i; k++) begin
          x = a[8*(i*N+k) +: 8];
          y = b[8*(k*N+j) +: 8];
          acc += longint'(x) * longint'(y);
        end
`ifdef TRI_MATMUL_SAT_EN
        if (acc > 127) acc = 127;
        else if (acc < -128) acc = -128;
`endif
        r[8*(i*N+j) +: 8] = acc[7:0];
      end
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    if (mif.done) begin
      dn_cnt++;
      if (sb.size() == 0)
        chk("unexpected_done", 1, 0);
      else
        chk("C_out", mif.C_out, sb.pop_front());
    end
  end

  task automatic launch(input logic [71:0] a, input logic [71:0] b,
                        input bit push);
    @(negedge clk);
    mif.A_in  = a;
    mif.B_in  = b;
    mif.start = 1'b1;
    if (push) sb.push_back(model(a, b));
    @(posedge clk);
    #1 mif.start = 1'b0;
  endtask

  task automatic wait_done(input int pre);
    int n;
    bit ok;
    n = pre;
    ok = 0;
    while (n < 60 && !ok) begin
      @(posedge clk);
      #1;
      n++;
      if (mif.done) ok = 1;
      else chk("busy_run", mif.busy, 1);
    end
    chk("latency", n, 16);
    chk("busy_end", mif.busy, 0);
  endtask

  logic [71:0] id, a2, a3, b3, d1, d2, dn;
  int t[9];
  int d0;

  initial begin
    mif.start = 1'b0;
    mif.A_in  = '0;
    mif.B_in  = '0;
    t = '{1,0,0, 0,1,0, 0,0,1};        id = mk(t);
    t = '{2,0,0, 1,3,0, -1,4,5};       a2 = mk(t);
    t = '{1,77,-3, 2,1,9, 3,4,1};      a3 = mk(t);
    t = '{1,-9,55, -2,1,100, 5,-4,1};  b3 = mk(t);
    t = '{100,0,0, 0,100,0, 0,0,100};  d1 = mk(t);
    t = '{-100,0,0, 0,-100,0, 0,0,-100}; dn = mk(t);
    t = '{5,0,0, 6,7,0, 8,9,10};       d2 = mk(t);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", mif.busy, 0);
    chk("rst_done", mif.done, 0);
    chk("rst_cout", mif.C_out, 0);
    @(negedge clk) rst = 1'b0;

    launch(id, id, 1);
    wait_done(0);
    chk("ident", mif.C_out, id);

    // back-to-back: next start lands in the done cycle
    launch(a2, id, 1);
    wait_done(0);
    chk("a_times_i", mif.C_out, a2);

    launch(a3, b3, 1);
    wait_done(0);
    chk("inverse", mif.C_out, id);

    launch(d1, d1, 1);
    wait_done(0);
`ifdef TRI_MATMUL_SAT_EN
    chk("sat_pos00", mif.C_out[7:0], 8'h7F);
    chk("sat_pos22", mif.C_out[71:64], 8'h7F);
`else
    chk("wrap_pos00", mif.C_out[7:0], 8'h10);
    chk("wrap_pos22", mif.C_out[71:64], 8'h10);
`endif

    launch(d1, dn, 1);
    wait_done(0);
`ifdef TRI_MATMUL_SAT_EN
    chk("sat_neg11", mif.C_out[39:32], 8'h80);
`else
    chk("wrap_neg11", mif.C_out[39:32], 8'hF0);
`endif

    // restart attempt at cycle 5, operand change at cycle 6
    launch(a2, a3, 1);
    repeat (4) @(posedge clk);
    @(negedge clk) mif.start = 1'b1;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    mif.A_in  = d2;
    wait_done(5);
    d0 = dn_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("no_restart_done", dn_cnt, d0);
    chk("no_restart_busy", mif.busy, 0);

    // abort with reset at cycle 8
    launch(d2, a3, 0);
    d0 = dn_cnt;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", mif.busy, 0);
    chk("abort_done", mif.done, 0);
    chk("abort_cout", mif.C_out, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_nodone", dn_cnt, d0);
    @(negedge clk) rst = 1'b0;

    launch(d2, a3, 1);
    wait_done(0);
    @(posedge clk);
    #1;
    chk("done_pulse", mif.done, 0);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tri_matmul.md
TRI_MATMUL -- requirements
Module: tri_matmul

Interface
REQ-001 The block SHALL have parameter N, default 3, as the matrix dimension (N x N, N >= 1).
REQ-002 The block SHALL have parameter W, default 8, as the element width in signed two's complement.
REQ-003 The block SHALL have port clk, input, 1 bit, as the clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, as the reset: asynchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit, as the request to begin one product; sampled only in IDLE.
REQ-006 The block SHALL have port A_in, input, W*N*N bits, as the lower-triangular left operand; element (i,j) is at bits [W*(i*N+j) +: W].
REQ-007 The block SHALL have port B_in, input, W*N*N bits, as the lower-triangular right operand, with the same layout as A_in.
REQ-008 The block SHALL have port busy, output, 1 bit, asserted while a product is in progress.
REQ-009 The block SHALL have port done, output, 1 bit, as a one-cycle completion pulse.
REQ-010 The block SHALL have port C_out, output, W*N*N bits, as the product C = A*B, with the same layout as A_in.

Function
REQ-011 The block SHALL use only the lower-triangle elements (j <= i) of A_in and B_in; upper-triangle input bits SHALL be ignored.
REQ-012 The block SHALL compute C[i][j] = sum over k = j..i of A[i][k]*B[k][j] for every j <= i, and SHALL drive all upper-triangle elements of C_out to 0.
REQ-013 The block SHALL implement an FSM with states IDLE, MAC and WRITE.
REQ-014 In IDLE with start=1, the block SHALL capture A_in and B_in into internal registers, set i=0, j=0, k=0, clear the accumulator, set busy=1 and go to MAC.
REQ-015 In MAC, the block SHALL perform one signed multiply-accumulate per cycle (acc += A[i][k]*B[k][j]); k SHALL increment, and when k==i the state SHALL go to WRITE.
REQ-016 The accumulator SHALL be signed with width 2W+clog2(N)+1, so that no intermediate overflow occurs.
REQ-017 In WRITE, the block SHALL store the reduced accumulator into internal C[i][j] and advance to the next element in row-major order: j++, or if j==i then i++ and j=0.
REQ-018 On advancing, the block SHALL set k to the new j, clear acc, and return to MAC.
REQ-019 On the WRITE of the last element (i=j=N-1), the block SHALL:
- load C_out from the internal C registers;
- assert done for exactly one cycle;
- deassert busy;
- return to IDLE.
REQ-020 Latency from the edge that samples start to the edge that raises done SHALL be N(N+1)/2 + N(N+1)(N+2)/6 edges, which is 16 for N=3.
REQ-021 start SHALL be ignored while busy=1; the operands SHALL NOT change mid-computation even if A_in or B_in change.
REQ-022 start=1 on the cycle in which done=1 SHALL be accepted, because the FSM is in IDLE; back-to-back products SHALL be supported.
REQ-023 C_out SHALL hold its last value until the next completion and SHALL NOT show partial results.

Reset
REQ-024 Asserting rst SHALL, asynchronously:
- set busy=0, done=0 and C_out=0;
- clear the internal registers;
- force the state to IDLE.
REQ-025 rst asserted mid-operation SHALL abort the product without pulsing done; the first start after reset release SHALL begin a fresh product.

Configuration
REQ-026 The feature SHALL be controlled by macro TRI_MATMUL_SAT_EN.
REQ-027 With TRI_MATMUL_SAT_EN defined, WRITE SHALL saturate the accumulator to the signed W-bit range [-2^(W-1), 2^(W-1)-1].
REQ-028 Without TRI_MATMUL_SAT_EN, WRITE SHALL keep the low W bits of the accumulator (wrap-around).

Verification (N=3, W=8)
REQ-029 The bench SHALL apply A = I and B = I, pulse start -> busy for 16 cycles, done pulses once, C_out = I.
REQ-030 The bench SHALL apply A = [[2,0,0],[1,3,0],[-1,4,5]] and B = I -> C_out = A.
REQ-031 The bench SHALL apply A = [[1,0,0],[2,1,0],[3,4,1]] and B = [[1,0,0],[-2,1,0],[5,-4,1]] -> C_out = I, with nonzero upper-triangle input bits having no effect.
REQ-032 The bench SHALL apply A = diag(100) with B = diag(100), and then B = diag(-100):
- with TRI_MATMUL_SAT_EN, diagonal elements = 127 and then -128;
- without it, diagonal elements = 0x10 and then 0xF0.
REQ-033 The bench SHALL pulse start again at cycle 5 of a product and change A_in at cycle 6 -> no restart, result matches the original operands, done comes at 16 cycles.
REQ-034 The bench SHALL assert rst at cycle 8 of a product -> busy=0, C_out=0, no done pulse; a new start then completes normally in 16 cycles.
